btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 131 +++++++++++++
 tb/tb_btn_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: N independent push-button channels. Each channel
// synchronises its raw input, debounces it over a stability window, and
// emits a clean level, one-cycle press/release pulses and optional
// auto-repeat pulses while the button is held.
//
// Handshake note: there is no valid/ready traffic here. press, release_pulse
// and rpt are single-cycle strobes qualified by nothing; a consumer samples
// them on any rising clk edge and must not expect them to be held.
//
// `release` is a reserved word in SystemVerilog, so the release strobe port
// is called release_pulse.
module btn_conditioner #(
  parameter int                  CHANNELS      = 3,
  parameter int                  STABLE_CYCLES = 1_000_000,
  parameter int                  REPEAT_DELAY  = 25_000_000,
  parameter int                  REPEAT_PERIOD = 5_000_000,
  parameter logic [CHANNELS-1:0] REPEAT_EN     = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] rpt,
  output logic [CHANNELS-1:0] evt
);

  localparam int              DW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [DW-1:0]   DLAST = DW'(STABLE_CYCLES - 1);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RLOAD_DELAY  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLOAD_PERIOD = RW'(REPEAT_PERIOD - 1);

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_ch
      logic          s1_q, s1_d;
      logic          s2_q, s2_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          release_q, release_d;
      logic [DW-1:0] dcnt_q, dcnt_d;

      // Synchroniser shift and debounce window: any cycle where the
      // synchronised input matches the accepted level restarts the window.
      always_comb begin
        s1_d      = btn_in[i];
        s2_d      = s1_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        dcnt_d    = '0;
        if (s2_q != level_q) begin
          if (dcnt_q == DLAST) begin
            level_d   = s2_q;
            press_d   = s2_q;
            release_d = ~s2_q;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
      end

      // Debounce state registers with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s1_q      <= 1'b0;
          s2_q      <= 1'b0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          dcnt_q    <= '0;
        end else begin
          s1_q      <= s1_d;
          s2_q      <= s2_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
          dcnt_q    <= dcnt_d;
        end
      end

      assign level[i]         = level_q;
      assign press[i]         = press_q;
      assign release_pulse[i] = release_q;

      if (REPEAT_EN[i]) begin : g_rep
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rpt_q, rpt_d;

        // Repeat countdown: reloaded on press, fires while held; a release
        // on the same edge suppresses the pulse and freezes the counter.
        always_comb begin
          rcnt_d = rcnt_q;
          rpt_d  = 1'b0;
          if (press_d) begin
            rcnt_d = RLOAD_DELAY;
          end else if (level_q && !release_d) begin
            if (rcnt_q == '0) begin
              rpt_d  = 1'b1;
              rcnt_d = RLOAD_PERIOD;
            end else begin
              rcnt_d = rcnt_q - RW'(1);
            end
          end
        end

        // Repeat state registers with synchronous active-low reset.
        always_ff @(posedge clk) begin
          if (!rst_n) begin
            rcnt_q <= '0;
            rpt_q  <= 1'b0;
          end else begin
            rcnt_q <= rcnt_d;
            rpt_q  <= rpt_d;
          end
        end

        assign rpt[i] = rpt_q;
      end else begin : g_norep
        assign rpt[i] = 1'b0;
      end
    end
  endgenerate

  assign evt = press | rpt;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: cycle-level scoreboard plus directed checks for the
// button conditioner with a short debounce window and fast repeat timing.
module tb_btn_conditioner;

  localparam int         CH     = 3;
  localparam int         STABLE = 4;
  localparam int         RD     = 6;
  localparam int         RP     = 3;
  localparam logic [2:0] REN    = 3'b010;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] level, press, release_pulse, rpt, evt;

  always #5 clk = ~clk;

  btn_conditioner #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (STABLE),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .REPEAT_EN     (REN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .rpt           (rpt),
    .evt           (evt)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [14:0] exp_q[$];

  // Reference model: pipeline, run length of disagreement, press timestamp.
  logic [2:0] m_s1    = '0;
  logic [2:0] m_s2    = '0;
  logic [2:0] m_level = '0;
  int         m_run[CH];
  int         m_press_cyc[CH];
  int         cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Advance the model by one rising edge with the given inputs and push
  // the outputs the DUT should show after that edge.
  task automatic model_edge(input logic [2:0] b, input logic r);
    logic [2:0] pr, rl, rp;
    int el;
    pr = '0; rl = '0; rp = '0;
    if (!r) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int c = 0; c < CH; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (m_s2[c] != m_level[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == STABLE) begin
          m_run[c] = 0;
          if (m_s2[c]) begin
            pr[c] = 1'b1;
            m_press_cyc[c] = cyc;
          end else begin
            rl[c] = 1'b1;
          end
        end else if (REN[c] && m_level[c]) begin
          el = cyc - m_press_cyc[c];
          if (el >= RD && ((el - RD) % RP) == 0) rp[c] = 1'b1;
        end
      end
      m_level = m_level ^ (pr | rl);
      m_s2 = m_s1;
      m_s1 = b;
    end
    exp_q.push_back({pr | rp, rp, rl, pr, m_level});
    cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic tick(input logic [2:0] b, input logic r);
    logic [14:0] exp_v;
    btn_in = b;
    rst_n  = r;
    model_edge(b, r);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: no expected entry at t=%0t", $time);
    end else begin
      exp_v = exp_q.pop_front();
      check_eq("sb", 32'({evt, rpt, release_pulse, press, level}), 32'(exp_v));
    end
  endtask

  // ---------------- stimulus ----------------
  logic seen;

  initial begin
    btn_in = '0;
    rst_n  = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_press_cyc[c] = 0;
    end

    // Buttons held through reset are ignored until after reset.
    repeat (3) tick(3'b111, 1'b0);
    check_eq("rst_outs", 32'({evt, rpt, release_pulse, press, level}), 32'(0));
    // Tick t samples btn_in on edge t after reset release.
    for (int t = 0; t <= 6; t++) begin
      tick(3'b111, 1'b1);
      if (t == 4) check_eq("rst_lvl_e4", 32'(level), 32'(3'b000));
      if (t == 5) begin
        check_eq("rst_press_e5", 32'(press), 32'(3'b111));
        check_eq("rst_lvl_e5", 32'(level), 32'(3'b111));
      end
      if (t == 6) check_eq("rst_press_e6", 32'(press), 32'(3'b000));
    end
    for (int t = 0; t <= 5; t++) begin
      tick(3'b000, 1'b1);
      if (t == 5) check_eq("rel_all", 32'(release_pulse), 32'(3'b111));
    end
    repeat (3) tick(3'b000, 1'b1);

    // Debounce latency on channel 0.
    for (int t = 0; t <= 6; t++) begin
      tick(3'b001, 1'b1);
      if (t == 4) check_eq("db_lvl_e4", 32'(level[0]), 32'(0));
      if (t == 5) check_eq("db_press_e5", 32'(press[0]), 32'(1));
      if (t == 6) check_eq("db_press_e6", 32'(press[0]), 32'(0));
    end
    for (int t = 0; t <= 5; t++) begin
      tick(3'b000, 1'b1);
      if (t == 4) check_eq("db_rel_e4", 32'(release_pulse[0]), 32'(0));
      if (t == 5) check_eq("db_rel_e5", 32'(release_pulse[0]), 32'(1));
    end
    repeat (2) tick(3'b000, 1'b1);

    // Glitch: a 3-cycle high run is one short of the window.
    seen = 1'b0;
    for (int t = 0; t < 3; t++) begin tick(3'b001, 1'b1); seen |= press[0]; end
    tick(3'b000, 1'b1); seen |= press[0];
    for (int t = 0; t < 3; t++) begin tick(3'b001, 1'b1); seen |= press[0]; end
    check_eq("gl_lvl", 32'(level[0]), 32'(0));
    check_eq("gl_nopress", 32'(seen), 32'(0));
    for (int k = 0; k < 3; k++) begin
      tick(3'b001, 1'b1);
      if (k == 1) check_eq("gl_press_early", 32'(press[0]), 32'(0));
      if (k == 2) check_eq("gl_press", 32'(press[0]), 32'(1));
    end
    repeat (6) tick(3'b000, 1'b1);
    repeat (2) tick(3'b000, 1'b1);

    // Auto-repeat on channel 1; channel 0 held alongside never repeats.
    for (int t = 0; t <= 5; t++) begin
      tick(3'b011, 1'b1);
      if (t == 5) check_eq("ar_evt_p", 32'(evt), 32'(3'b011));
    end
    seen = 1'b0;
    for (int u = 1; u <= 13; u++) begin
      tick(3'b011, 1'b1);
      seen |= rpt[0];
      if (u == 6 || u == 9 || u == 12) begin
        check_eq("ar_rpt1", 32'(rpt[1]), 32'(1));
        check_eq("ar_evt1", 32'(evt[1]), 32'(1));
      end
      if (u == 7) check_eq("ar_rpt1_gap", 32'(rpt[1]), 32'(0));
    end
    check_eq("ar_norpt0", 32'(seen), 32'(0));
    repeat (9) tick(3'b000, 1'b1);

    // Release lands on the edge a repeat would fire: release wins.
    for (int t = 0; t <= 5; t++) tick(3'b010, 1'b1);
    seen = 1'b0;
    for (int u = 1; u <= 12; u++) begin
      tick((u < 4) ? 3'b010 : 3'b000, 1'b1);
      if (u == 6) check_eq("rr_rpt_p6", 32'(rpt[1]), 32'(1));
      if (u == 9) begin
        check_eq("rr_rel_p9", 32'(release_pulse[1]), 32'(1));
        check_eq("rr_rpt_p9", 32'(rpt[1]), 32'(0));
      end
      if (u > 9) seen |= rpt[1];
    end
    check_eq("rr_norpt_after", 32'(seen), 32'(0));
    repeat (2) tick(3'b000, 1'b1);

    // Reset in the middle of a repeat sequence.
    for (int t = 0; t <= 5; t++) tick(3'b010, 1'b1);
    for (int u = 1; u <= 6; u++) tick(3'b010, 1'b1);
    tick(3'b010, 1'b0);
    check_eq("mr_outs", 32'({evt, rpt, release_pulse, press, level}), 32'(0));
    for (int v = 1; v <= 12; v++) begin
      tick(3'b010, 1'b1);
      if (v == 2)  check_eq("mr_norpt_p9", 32'(rpt[1]), 32'(0));
      if (v == 5)  check_eq("mr_press_early", 32'(press[1]), 32'(0));
      if (v == 6)  check_eq("mr_press", 32'(press[1]), 32'(1));
      if (v == 11) check_eq("mr_rpt_early", 32'(rpt[1]), 32'(0));
      if (v == 12) check_eq("mr_rpt", 32'(rpt[1]), 32'(1));
    end

    // Random held patterns with occasional reset, checked by the scoreboard.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] b;
      logic       r;
      int         dur;
      b   = 3'($urandom_range(0, 7));
      r   = ($urandom_range(0, 30) != 0);
      dur = $urandom_range(1, 12);
      for (int d = 0; d < dur; d++) tick(b, r);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
